// File: rtl/montmult_ws_gen.sv
// -----------------------------------------------------------------------------
// montmult_ws_gen
//
// Word-serial Montgomery multiplier. Computes
//   product = A * B * R^-1 mod M,   R = 2^(WORD * N_ITER)
// one WORD-bit digit of the multiplier per clock. The modulus M and
// M' = -M^-1 mod 2^WORD are loaded with each operation. An optional final
// conditional subtraction brings the result from [0, 2M) into [0, M).
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   start         operation request, accepted only in IDLE or DONE
//   multiplier    operand A (A < 2M), M_LENGTH+WORD bits
//   multiplicand  operand B (B < 2M), M_LENGTH+WORD bits
//   modulus       odd modulus M, M_LENGTH bits
//   m_dash        M' = -M^-1 mod 2^WORD
//   final_sub_en  1: result reduced to [0, M); 0: result left in [0, 2M)
//   busy          high while iterating or subtracting
//   done          one-cycle pulse when the result is valid
//   product       result, held until the next accepted start
// -----------------------------------------------------------------------------
module montmult_ws_gen #(
  parameter int M_LENGTH = 512,
  parameter int WORD     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [M_LENGTH+WORD-1:0] multiplier,
  input  logic [M_LENGTH+WORD-1:0] multiplicand,
  input  logic [M_LENGTH-1:0]      modulus,
  input  logic [WORD-1:0]          m_dash,
  input  logic                     final_sub_en,
  output logic                     busy,
  output logic                     done,
  output logic [M_LENGTH+WORD-1:0] product
);

  localparam int NUM_WORDS = M_LENGTH / WORD;
  localparam int N_ITER    = NUM_WORDS + 1;
  localparam int OP_W      = M_LENGTH + WORD;
  localparam int ACC_W     = M_LENGTH + 2 * WORD + 2;
  // T is the accumulator after the WORD-bit shift, so nothing is lost.
  localparam int T_W       = ACC_W - WORD;
  localparam int CNT_W     = $clog2(N_ITER + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_SUB  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [OP_W-1:0]   a_q, a_d;       // multiplier, shifted down one digit per iteration
  logic [OP_W-1:0]   b_q, b_d;
  logic [M_LENGTH-1:0] m_q, m_d;
  logic [WORD-1:0]   mdash_q, mdash_d;
  logic              fsub_q, fsub_d;
  logic [T_W-1:0]    t_q, t_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [OP_W-1:0]   prod_q, prod_d;

  logic [WORD-1:0]   a_dig_s;
  logic [WORD-1:0]   u_s;
  logic [WORD-1:0]   q_s;
  logic [ACC_W-1:0]  acc_s;
  logic [T_W-1:0]    t_iter_s;
  logic              t_ge_m_s;
  logic [T_W-1:0]    t_sub_s;

  // Digit datapath: quotient digit, accumulate, shift, and conditional subtract.
  always_comb begin
    a_dig_s  = a_q[WORD-1:0];
    // Only the low digit of T + a_i*B matters for q, so this runs at WORD width.
    u_s      = t_q[WORD-1:0] + a_dig_s * b_q[WORD-1:0];
    q_s      = u_s * mdash_q;
    acc_s    = ACC_W'(t_q) + ACC_W'(a_dig_s) * ACC_W'(b_q) + ACC_W'(q_s) * ACC_W'(m_q);
    // Low WORD bits of acc_s are zero by choice of q.
    t_iter_s = T_W'(acc_s >> WORD);
    t_ge_m_s = (t_q >= T_W'(m_q));
    t_sub_s  = t_q - T_W'(m_q);
  end

  // Next-state and register-input logic for the control FSM.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    mdash_d = mdash_q;
    fsub_d  = fsub_q;
    t_d     = t_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = multiplier;
          b_d     = multiplicand;
          m_d     = modulus;
          mdash_d = m_dash;
          fsub_d  = final_sub_en;
          t_d     = '0;
          cnt_d   = '0;
          state_d = S_ITER;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ITER: begin
        a_d   = a_q >> WORD;
        t_d   = t_iter_s;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N_ITER - 1)) begin
          if (fsub_q) begin
            state_d = S_SUB;
          end else begin
            state_d = S_DONE;
            prod_d  = OP_W'(t_iter_s);
          end
        end else begin
          state_d = S_ITER;
        end
      end
      S_SUB: begin
        if (t_ge_m_s) begin
          t_d    = t_sub_s;
          prod_d = OP_W'(t_sub_s);
        end else begin
          t_d    = t_q;
          prod_d = OP_W'(t_q);
        end
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_ITER) || (state_d == S_SUB);
    done_d = (state_d == S_DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      mdash_q <= '0;
      fsub_q  <= 1'b0;
      t_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      mdash_q <= mdash_d;
      fsub_q  <= fsub_d;
      t_q     <= t_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      prod_q  <= prod_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = prod_q;

endmodule

// File: doc/montmult_ws_gen.md
Name: montmult_ws_gen

Overview:
- Parametrised word-serial Montgomery multiplier. Computes product ≡ A·B·R⁻¹ mod M, with R = 2^(WORD·N_ITER).
- Successor to the fixed 16-bit, hard-coded-modulus multiplier. Word width and operand length are parameters.
- Modulus and M' are loaded per operation through ports, not selected from constants.
- Adds a start/busy/done handshake, an optional final conditional subtraction, and asynchronous reset.
- Sits under the Paillier encrypt/decrypt exponentiation controllers, which drive it once per square/multiply step.

Parameters:
- M_LENGTH, 512, modulus width in bits; must be a multiple of WORD and at least 2·WORD.
- WORD, 16, digit width per iteration: 8, 16, 32 or 64.
- NUM_WORDS, M_LENGTH/WORD, derived; not to be overridden.
- N_ITER, NUM_WORDS+1, derived; number of digit iterations (operands are one word wider than M).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE or DONE.
- multiplier  in  M_LENGTH+WORD  operand A; must satisfy A < 2M.
- multiplicand  in  M_LENGTH+WORD  operand B; must satisfy B < 2M.
- modulus  in  M_LENGTH  M; must be odd.
- m_dash  in  WORD  M' = −M⁻¹ mod 2^WORD.
- final_sub_en  in  1  1 = reduce the result to [0, M); 0 = result left in [0, 2M).
- busy  out  1  high in ITER and SUB.
- done  out  1  one-cycle pulse in DONE.
- product  out  M_LENGTH+WORD  result; held stable until the next accepted start.

Behaviour:
- Reset: when rst_n=0, state goes to IDLE immediately. busy=0, done=0, product=0, all internal registers=0, counter=0.
  - Reset during ITER or SUB aborts the operation. No done is produced.
- FSM states: IDLE, ITER, SUB, DONE.
- IDLE: when start=1, capture A, B, M, m_dash and final_sub_en; clear T; set counter=0; go to ITER.
  - Input ports are don't-care after the capture edge.
- ITER: one digit per cycle, using the counter-selected digit a_i = A[WORD·i +: WORD]:
  - q = ((T[WORD-1:0] + a_i·B[WORD-1:0]) · m_dash) mod 2^WORD.
  - T ← (T + a_i·B + q·M) >> WORD. The low WORD bits of the sum are zero by construction.
  - The accumulator is M_LENGTH+2·WORD+2 bits wide; no truncation before the shift.
  - counter increments each cycle. After iteration N_ITER−1: go to SUB if final_sub_en=1, else go to DONE.
- SUB: if T ≥ M then T ← T − M; otherwise T is unchanged. Then go to DONE. Exactly one cycle.
- DONE: done=1, busy=0, product=T (registered).
  - start=1 in DONE is accepted exactly as in IDLE, allowing back-to-back operation with no bubble.
  - Otherwise go to IDLE.
- start while busy=1 is ignored. No queueing, no error flag.
- Latency, measured from the edge that samples start to the first cycle with done=1:
  - N_ITER+1 cycles with final_sub_en=1.
  - N_ITER cycles with final_sub_en=0.
- Range guarantee: with A, B < 2M and 4M < R, T < 2M at the end of ITER. After SUB, T < M.
- product updates only on entry to DONE. Between operations it holds the last result.

Test Plan:
- M_LENGTH=32, WORD=16 (N_ITER=3, R=2^48), M=13, m_dash=0xB13B, final_sub_en=1, A=1, B=1 → done 4 cycles after start edge; product=1 (R⁻¹ ≡ 1 mod 13).
- Same configuration, A=5, B=7 → product=9. Then A=0, B=12 → product=0.
- Same configuration with final_sub_en=0, A=5, B=7 → done 3 cycles after start edge; product ≡ 9 mod 13 and product < 26.
- Back-to-back: assert start again in the DONE cycle with A=2, B=3 → second done exactly 4 cycles later, product=6. A start pulse mid-ITER is ignored: the result and done timing are unchanged.
- Assert rst_n=0 in ITER counter=1 → busy, done and product go to 0 asynchronously. After release, a fresh start yields correct results and no stale done pulse appears.
- Default M_LENGTH=512, WORD=16, Paillier N² modulus with 1000 random A, B < 2M, both final_sub_en values → bit-exact against a software model of A·B·2^(−16·33) mod M; latency 34 or 33 cycles.
